mesh_io_sequencer: RTL and testbench
====================================

Name: mesh_io_sequencer

Overview:
Top-level controller for the subdivision engine. Sequences the three phases: SPI load of the input mesh into the object RAM, subsurf run, SPI unload of the result. Owns the object RAM port during load/unload and hands it to the subsurf engine during run via ram_sel. Adds a terminator-framed word protocol, overflow protection and a run timeout.

Parameters:
ADDR_WIDTH, 11, object RAM address width; DEPTH = 2**ADDR_WIDTH words
TERMINATOR, 32'hFFFFFFFF, frame-end word in both directions
RUN_TIMEOUT, 65535, max cycles from ss_start to busy falling; 16-bit counter

Ports:
clk  in  1  system clock
rstb  in  1  asynchronous active-low reset
rx_valid  in  1  one-cycle pulse: rx_data holds a received SPI word (clk domain)
rx_data  in  32  received word
tx_data  out  32  word to be shifted out by the SPI slave
tx_load  out  1  one-cycle pulse: tx_data valid, SPI loads shifter
tx_ack  in  1  one-cycle pulse: SPI finished shifting current word
ram_en  out  1  object RAM enable
ram_we  out  4  object RAM byte write enables
ram_addr  out  ADDR_WIDTH  object RAM address
ram_din  out  32  object RAM write data
ram_dout  in  32  object RAM read data, 1-cycle latency
ram_sel  out  1  0 = sequencer drives RAM, 1 = subsurf drives RAM
ss_start  out  1  one-cycle start pulse to subsurf
ss_busy  in  1  subsurf busy
ss_word_count  in  32  result word count, valid when ss_busy falls
load_count  out  ADDR_WIDTH+1  words stored in last load
err_overflow  out  1  sticky; cleared on next LOAD entry
err_timeout  out  1  sticky; cleared on next LOAD entry

Behaviour:
- Reset (rstb low, async): state LOAD; all outputs 0 (tx_data 0, ram_sel 0, load_count 0, errors 0); word counter and address 0.
- States: LOAD, START, WAIT_BUSY, RUN, FETCH, PRESENT, TERM.
- LOAD: on rx_valid with rx_data != TERMINATOR, if wcnt < DEPTH: ram_en=1, ram_we=4'hF, ram_addr=wcnt, ram_din=rx_data that same cycle; wcnt++. If wcnt == DEPTH, drop the word and set err_overflow.
- LOAD on TERMINATOR: if wcnt == 0, ignore it and stay in LOAD. Otherwise load_count <= wcnt and go to START.
- START: ram_sel=1; ss_start=1 for exactly one cycle; timeout counter cleared; go to WAIT_BUSY.
- WAIT_BUSY: wait for ss_busy=1, then go to RUN. RUN: wait for ss_busy=0, then latch ucnt = min(ss_word_count, DEPTH), addr=0, ram_sel=0.
  - If ucnt == 0, go to TERM; else go to FETCH.
- Timeout: counter runs in WAIT_BUSY and RUN. When it reaches RUN_TIMEOUT, set err_timeout, ram_sel=0, ucnt=0, go to TERM.
- FETCH: ram_en=1, ram_we=0, ram_addr=addr for one cycle, then go to PRESENT.
- PRESENT: on entry cycle, tx_data <= ram_dout and tx_load pulses once. Hold until tx_ack, then addr++. If addr+1 == ucnt go to TERM, else go to FETCH.
  - Per-word cost: 2 cycles plus the SPI shift time.
- TERM: tx_data <= TERMINATOR, tx_load pulse once. On tx_ack go to LOAD, wcnt=0, errors cleared.
- rx_valid outside LOAD is ignored. tx_ack outside PRESENT/TERM is ignored. rx_valid and a TERMINATOR in the same cycle behave as a normal terminator.
- ram outputs are 0 whenever ram_sel=1 (top muxes in subsurf signals).
- Reset mid-operation: immediate return to the reset state. No pending writes; no tx_load pulse emitted.

Test Plan:
- Load 0x11,0x22,0x33,TERM -> RAM writes 0x11@0, 0x22@1, 0x33@2; load_count=3; ss_start high exactly 1 cycle; ram_sel=1.
- ss_busy high 10 cycles then low with ss_word_count=2; RAM[0]=0xA0, RAM[1]=0xA1 -> tx_data sequence 0xA0, 0xA1, 0xFFFFFFFF, each word after a tx_ack; state returns to LOAD.
- TERM as first word -> no write, no ss_start, state stays LOAD.
- ADDR_WIDTH=3, 9 data words + TERM -> 8 writes (addr 0..7), 9th dropped; err_overflow=1; load_count=8.
- RUN_TIMEOUT=20, ss_busy never rises -> err_timeout at cycle 20 after ss_start; only the TERMINATOR is sent; errors clear on return to LOAD.
- rstb pulsed low during PRESENT -> all outputs 0 asynchronously; after release, a fresh load of 1 word + TERM works correctly.

Source files
------------

// File: rtl/mesh_io_sequencer.sv
// mesh_io_sequencer: top-level phase controller for the subdivision engine.
// Loads a terminator-framed mesh over SPI into the object RAM, hands the RAM
// to the subsurf engine for the run, then unloads the result over SPI followed
// by a terminator word. Overflowing words are dropped and a stuck run times out.
//
// Ports:
//   clk, rstb                  clock, asynchronous active-low reset
//   rx_valid, rx_data          received SPI word strobe and data
//   tx_data, tx_load, tx_ack   transmit word, load strobe, shift-done strobe
//   ram_en/we/addr/din/dout    object RAM port (driven combinationally, 0 when ram_sel)
//   ram_sel                    0: sequencer owns RAM, 1: subsurf owns RAM
//   ss_start, ss_busy          subsurf start pulse and busy flag
//   ss_word_count              result word count, valid when ss_busy falls
//   load_count                 words stored by the last load
//   err_overflow, err_timeout  sticky error flags, cleared when returning to LOAD
module mesh_io_sequencer #(
    parameter int unsigned ADDR_WIDTH  = 11,
    parameter logic [31:0] TERMINATOR  = 32'hFFFF_FFFF,
    parameter int unsigned RUN_TIMEOUT = 65535
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  rx_valid,
    input  logic [31:0]           rx_data,
    output logic [31:0]           tx_data,
    output logic                  tx_load,
    input  logic                  tx_ack,
    output logic                  ram_en,
    output logic [3:0]            ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_din,
    input  logic [31:0]           ram_dout,
    output logic                  ram_sel,
    output logic                  ss_start,
    input  logic                  ss_busy,
    input  logic [31:0]           ss_word_count,
    output logic [ADDR_WIDTH:0]   load_count,
    output logic                  err_overflow,
    output logic                  err_timeout
);

    localparam int unsigned CW       = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [15:0]   TMO_LAST = 16'(RUN_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_LOAD, S_START, S_WAIT_BUSY, S_RUN, S_FETCH, S_PRESENT, S_TERM
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic [CW-1:0] addr_q, addr_d;
    logic [CW-1:0] ucnt_q, ucnt_d;
    logic [15:0]   tcnt_q, tcnt_d;
    logic [CW-1:0] load_count_q, load_count_d;
    logic [31:0]   tx_data_q, tx_data_d;
    logic          tx_load_q, tx_load_d;
    logic          ss_start_q, ss_start_d;
    logic          ram_sel_q, ram_sel_d;
    logic          err_ovf_q, err_ovf_d;
    logic          err_tmo_q, err_tmo_d;
    logic          issue_q, issue_d;
    logic [CW-1:0] wc_clamp;

    // Result word count clamped to the RAM depth.
    assign wc_clamp = (ss_word_count > 32'(DEPTH)) ? DEPTH_C : CW'(ss_word_count);

    // State and output registers.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q      <= S_LOAD;
            wcnt_q       <= '0;
            addr_q       <= '0;
            ucnt_q       <= '0;
            tcnt_q       <= '0;
            load_count_q <= '0;
            tx_data_q    <= '0;
            tx_load_q    <= 1'b0;
            ss_start_q   <= 1'b0;
            ram_sel_q    <= 1'b0;
            err_ovf_q    <= 1'b0;
            err_tmo_q    <= 1'b0;
            issue_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            addr_q       <= addr_d;
            ucnt_q       <= ucnt_d;
            tcnt_q       <= tcnt_d;
            load_count_q <= load_count_d;
            tx_data_q    <= tx_data_d;
            tx_load_q    <= tx_load_d;
            ss_start_q   <= ss_start_d;
            ram_sel_q    <= ram_sel_d;
            err_ovf_q    <= err_ovf_d;
            err_tmo_q    <= err_tmo_d;
            issue_q      <= issue_d;
        end
    end

    // Next-state, RAM port and transmit control.
    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        addr_d       = addr_q;
        ucnt_d       = ucnt_q;
        tcnt_d       = tcnt_q;
        load_count_d = load_count_q;
        tx_data_d    = tx_data_q;
        tx_load_d    = 1'b0;
        ss_start_d   = 1'b0;
        ram_sel_d    = ram_sel_q;
        err_ovf_d    = err_ovf_q;
        err_tmo_d    = err_tmo_q;
        ram_en       = 1'b0;
        ram_we       = 4'h0;
        ram_addr     = '0;
        ram_din      = '0;

        case (state_q)
            S_LOAD: begin
                if (rx_valid) begin
                    if (rx_data == TERMINATOR) begin
                        // An empty frame is ignored.
                        if (wcnt_q != '0) begin
                            load_count_d = wcnt_q;
                            ss_start_d   = 1'b1;
                            ram_sel_d    = 1'b1;
                            state_d      = S_START;
                        end
                    end else if (wcnt_q < DEPTH_C) begin
                        ram_en   = 1'b1;
                        ram_we   = 4'hF;
                        ram_addr = wcnt_q[ADDR_WIDTH-1:0];
                        ram_din  = rx_data;
                        wcnt_d   = wcnt_q + CW'(1);
                    end else begin
                        err_ovf_d = 1'b1;
                    end
                end
            end
            S_START: begin
                // Counter holds cycles elapsed since the ss_start cycle.
                tcnt_d  = 16'd1;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY, S_RUN: begin
                tcnt_d = tcnt_q + 16'd1;
                if (state_q == S_RUN && !ss_busy) begin
                    ucnt_d    = wc_clamp;
                    addr_d    = '0;
                    ram_sel_d = 1'b0;
                    state_d   = (wc_clamp == '0) ? S_TERM : S_FETCH;
                end else if (tcnt_q == TMO_LAST) begin
                    err_tmo_d = 1'b1;
                    ram_sel_d = 1'b0;
                    ucnt_d    = '0;
                    state_d   = S_TERM;
                end else if (state_q == S_WAIT_BUSY && ss_busy) begin
                    state_d = S_RUN;
                end
            end
            S_FETCH: begin
                ram_en   = 1'b1;
                ram_addr = addr_q[ADDR_WIDTH-1:0];
                state_d  = S_PRESENT;
            end
            S_PRESENT: begin
                // First cycle captures the RAM read; later cycles wait for the shift.
                if (issue_q) begin
                    tx_data_d = ram_dout;
                    tx_load_d = 1'b1;
                end else if (tx_ack) begin
                    addr_d  = addr_q + CW'(1);
                    state_d = (addr_q + CW'(1) == ucnt_q) ? S_TERM : S_FETCH;
                end
            end
            S_TERM: begin
                if (issue_q) begin
                    tx_data_d = TERMINATOR;
                    tx_load_d = 1'b1;
                end else if (tx_ack) begin
                    wcnt_d    = '0;
                    err_ovf_d = 1'b0;
                    err_tmo_d = 1'b0;
                    state_d   = S_LOAD;
                end
            end
            default: state_d = S_LOAD;
        endcase

        issue_d = (state_d != state_q) && (state_d == S_PRESENT || state_d == S_TERM);
    end

    assign tx_data      = tx_data_q;
    assign tx_load      = tx_load_q;
    assign ss_start     = ss_start_q;
    assign ram_sel      = ram_sel_q;
    assign load_count   = load_count_q;
    assign err_overflow = err_ovf_q;
    assign err_timeout  = err_tmo_q;

endmodule

// File: tb/tb_mesh_io_sequencer.sv
// Testbench for mesh_io_sequencer: small RAM model, auto-acking SPI model and
// scoreboards for RAM writes and transmitted words.
module tb_mesh_io_sequencer;

    localparam int unsigned AW   = 3;
    localparam logic [31:0] TERM = 32'hFFFF_FFFF;

    logic          clk = 1'b0;
    logic          rstb;
    logic          rx_valid;
    logic [31:0]   rx_data;
    logic [31:0]   tx_data;
    logic          tx_load;
    logic          tx_ack;
    logic          ram_en;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_din;
    logic [31:0]   ram_dout;
    logic          ram_sel;
    logic          ss_start;
    logic          ss_busy;
    logic [31:0]   ss_word_count;
    logic [AW:0]   load_count;
    logic          err_overflow;
    logic          err_timeout;

    mesh_io_sequencer #(.ADDR_WIDTH(AW), .TERMINATOR(TERM), .RUN_TIMEOUT(20)) dut (
        .clk(clk), .rstb(rstb),
        .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_data(tx_data), .tx_load(tx_load), .tx_ack(tx_ack),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout), .ram_sel(ram_sel),
        .ss_start(ss_start), .ss_busy(ss_busy), .ss_word_count(ss_word_count),
        .load_count(load_count), .err_overflow(err_overflow), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t         exp_wr[$];
    logic [31:0] exp_tx[$];
    logic [31:0] mem [0:7];
    int          ss_start_cnt = 0;
    bit          spi_auto     = 1'b1;

    // Object RAM model with one-cycle read latency.
    always @(posedge clk) begin
        if (ram_en && ram_we == 4'hF) mem[ram_addr] <= ram_din;
        if (ram_en) ram_dout <= mem[ram_addr];
    end

    // Scoreboard monitors, sampled on the falling edge.
    always @(negedge clk) begin
        wr_t         e;
        logic [31:0] t;
        if (rstb && ram_en && ram_we != 4'h0) begin
            checks++;
            if (exp_wr.size() == 0) begin
                failures++;
                $display("FAIL ram_write: unexpected write addr=%0d data=%h", ram_addr, ram_din);
            end else begin
                e = exp_wr.pop_front();
                if (ram_addr !== e.addr || ram_din !== e.data || ram_we !== 4'hF) begin
                    failures++;
                    $display("FAIL ram_write: got addr=%0d data=%h we=%h, want addr=%0d data=%h we=f",
                             ram_addr, ram_din, ram_we, e.addr, e.data);
                end
            end
        end
        if (tx_load) begin
            checks++;
            if (exp_tx.size() == 0) begin
                failures++;
                $display("FAIL tx_word: unexpected tx_load data=%h", tx_data);
            end else begin
                t = exp_tx.pop_front();
                if (tx_data !== t) begin
                    failures++;
                    $display("FAIL tx_word: got %h, want %h", tx_data, t);
                end
            end
        end
        if (ram_sel) begin
            checks++;
            if ({ram_en, ram_we, ram_addr, ram_din} !== '0) begin
                failures++;
                $display("FAIL ram_quiet: ram port active while ram_sel=1 en=%b we=%h", ram_en, ram_we);
            end
        end
        if (ss_start) ss_start_cnt++;
    end

    // SPI slave model: acknowledges each loaded word a few cycles later.
    always begin
        @(negedge clk);
        if (tx_load && spi_auto) begin
            repeat (3) @(posedge clk);
            #1 tx_ack = 1'b1;
            @(posedge clk);
            #1 tx_ack = 1'b0;
        end
    end

    // Watchdog.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_word(input logic [31:0] d);
        rx_valid = 1'b1;
        rx_data  = d;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = '0;
    endtask

    task automatic wait_ss_start(input logic [AW:0] exp_lc);
        bit seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ss_start) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL ss_start_seen: no ss_start within 10 cycles");
        end else begin
            checks++;
            if (ram_sel !== 1'b1) begin
                failures++;
                $display("FAIL ram_sel_run: got %b, want 1", ram_sel);
            end
            checks++;
            if (load_count !== exp_lc) begin
                failures++;
                $display("FAIL load_count: got %0d, want %0d", load_count, exp_lc);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_subsurf(input int busy_cycles, input logic [31:0] wc);
        ss_word_count = wc;
        ss_busy       = 1'b1;
        repeat (busy_cycles) @(posedge clk);
        #1 ss_busy = 1'b0;
    endtask

    task automatic wait_tx_done(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_tx.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL tx_done: %0d words still pending, want 0", exp_tx.size());
        end
    endtask

    task automatic test_reset();
        rstb = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({tx_data, tx_load, ram_en, ram_we, ram_addr, ram_din, ram_sel, ss_start} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: tx_data=%h tx_load=%b ram_en=%b ram_sel=%b ss_start=%b, want all 0",
                     tx_data, tx_load, ram_en, ram_sel, ss_start);
        end
        checks++;
        if ({load_count, err_overflow, err_timeout} !== '0) begin
            failures++;
            $display("FAIL reset_status: load_count=%0d ovf=%b tmo=%b, want 0",
                     load_count, err_overflow, err_timeout);
        end
        @(posedge clk);
        #1 rstb = 1'b1;
    endtask

    task automatic test_load_run_unload();
        int start_base = ss_start_cnt;
        exp_wr.push_back('{addr: 3'd0, data: 32'h11});
        exp_wr.push_back('{addr: 3'd1, data: 32'h22});
        exp_wr.push_back('{addr: 3'd2, data: 32'h33});
        send_word(32'h11);
        send_word(32'h22);
        send_word(32'h33);
        send_word(TERM);
        wait_ss_start(4'd3);
        mem[0] = 32'hA0;
        mem[1] = 32'hA1;
        exp_tx.push_back(32'hA0);
        exp_tx.push_back(32'hA1);
        exp_tx.push_back(TERM);
        run_subsurf(10, 32'd2);
        wait_tx_done(200);
        checks++;
        if (ss_start_cnt - start_base !== 1) begin
            failures++;
            $display("FAIL ss_start_width: high %0d cycles, want 1", ss_start_cnt - start_base);
        end
        checks++;
        if (exp_wr.size() != 0 || ram_sel !== 1'b0) begin
            failures++;
            $display("FAIL load_writes: pending=%0d ram_sel=%b, want 0 and 0", exp_wr.size(), ram_sel);
        end
    endtask

    task automatic test_term_first();
        int start_base = ss_start_cnt;
        send_word(TERM);
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (ss_start_cnt !== start_base || ram_sel !== 1'b0) begin
            failures++;
            $display("FAIL term_first: ss_start pulses=%0d ram_sel=%b, want 0 and 0",
                     ss_start_cnt - start_base, ram_sel);
        end
        checks++;
        if (load_count !== 4'd3) begin
            failures++;
            $display("FAIL term_first_count: load_count=%0d, want 3", load_count);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 8; i++) exp_wr.push_back('{addr: AW'(i), data: 32'h100 + 32'(i)});
        for (int i = 0; i < 9; i++) send_word(32'h100 + 32'(i));
        checks++;
        if (err_overflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow_flag: got %b, want 1", err_overflow);
        end
        send_word(TERM);
        wait_ss_start(4'd8);
        for (int i = 0; i < 8; i++) exp_tx.push_back(32'h100 + 32'(i));
        exp_tx.push_back(TERM);
        run_subsurf(3, 32'd100);
        wait_tx_done(400);
        checks++;
        if (err_overflow !== 1'b0 || exp_wr.size() != 0) begin
            failures++;
            $display("FAIL overflow_clear: err_overflow=%b pending writes=%0d, want 0 and 0",
                     err_overflow, exp_wr.size());
        end
    endtask

    task automatic test_timeout();
        bit seen = 1'b0;
        int tk   = -1;
        exp_wr.push_back('{addr: 3'd0, data: 32'h55});
        send_word(32'h55);
        send_word(TERM);
        exp_tx.push_back(TERM);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ss_start) begin
                seen = 1'b1;
                break;
            end
        end
        if (seen) begin
            for (int k = 1; k <= 40; k++) begin
                @(negedge clk);
                if (err_timeout) begin
                    tk = k;
                    break;
                end
            end
        end
        checks++;
        if (tk != 20) begin
            failures++;
            $display("FAIL timeout_cycle: err_timeout after %0d cycles, want 20", tk);
        end
        checks++;
        if (ram_sel !== 1'b0) begin
            failures++;
            $display("FAIL timeout_ram_sel: got %b, want 0", ram_sel);
        end
        @(posedge clk);
        #1;
        wait_tx_done(100);
        checks++;
        if (err_timeout !== 1'b0) begin
            failures++;
            $display("FAIL timeout_clear: err_timeout=%b, want 0", err_timeout);
        end
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        exp_wr.push_back('{addr: 3'd0, data: 32'hB0});
        exp_wr.push_back('{addr: 3'd1, data: 32'hB1});
        send_word(32'hB0);
        send_word(32'hB1);
        send_word(TERM);
        wait_ss_start(4'd2);
        mem[0]   = 32'hC0;
        spi_auto = 1'b0;
        exp_tx.push_back(32'hC0);
        run_subsurf(2, 32'd2);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx_load) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL present_reached: no tx_load within 50 cycles");
        end
        @(posedge clk);
        #1 rstb = 1'b0;
        #1;
        checks++;
        if ({tx_data, tx_load, ram_en, ram_we, ram_addr, ram_din, ram_sel, ss_start} !== '0) begin
            failures++;
            $display("FAIL async_reset_outputs: tx_data=%h tx_load=%b ram_en=%b ram_sel=%b, want all 0",
                     tx_data, tx_load, ram_en, ram_sel);
        end
        checks++;
        if ({load_count, err_overflow, err_timeout} !== '0) begin
            failures++;
            $display("FAIL async_reset_status: load_count=%0d ovf=%b tmo=%b, want 0",
                     load_count, err_overflow, err_timeout);
        end
        @(posedge clk);
        #1 rstb  = 1'b1;
        spi_auto = 1'b1;
        exp_wr.push_back('{addr: 3'd0, data: 32'h77});
        send_word(32'h77);
        send_word(TERM);
        wait_ss_start(4'd1);
        exp_tx.push_back(32'h77);
        exp_tx.push_back(TERM);
        run_subsurf(2, 32'd1);
        wait_tx_done(100);
        checks++;
        if (exp_wr.size() != 0) begin
            failures++;
            $display("FAIL post_reset_writes: %0d pending, want 0", exp_wr.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = '0;
        ram_dout      = '0;
        rx_valid      = 1'b0;
        rx_data       = '0;
        tx_ack        = 1'b0;
        ss_busy       = 1'b0;
        ss_word_count = '0;
        test_reset();
        test_load_run_unload();
        test_term_first();
        test_overflow();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
